// File: rtl/conv_window_addr_gen.sv
`default_nettype none
// ============================================================================
// Module      : conv_window_addr_gen
// Description : Scans a feature map with a 3x3 window at stride 1 or 2 and
//               drives the nine (w,h) tap read addresses for memory_part.
//               fmap_valid/out_x/out_y follow each issue by one cycle to
//               line up with the registered memory read.
// Revision    : 1.0 - initial release
// ============================================================================
module conv_window_addr_gen #(
    parameter int width    = 80,
    parameter int width_b  = 7,
    parameter int height_b = 3
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    start,
    input  logic [width_b-1:0]      fmap_w,
    input  logic [height_b:0]       fmap_h,
    input  logic                    stride,
    input  logic                    hold,
    output logic [width_b*9-1:0]    readi_w,
    output logic [height_b*9-1:0]   readi_h,
    output logic                    addr_valid,
    output logic                    fmap_valid,
    output logic [width_b-1:0]      out_x,
    output logic [height_b-1:0]     out_y,
    output logic                    busy,
    output logic                    done,
    output logic                    cfg_err
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    localparam logic [width_b:0]  c_max_w = (width_b+1)'(width);
    localparam logic [height_b:0] c_max_h = (height_b+1)'(2**height_b);
    localparam logic [width_b:0]  c_min_w = (width_b+1)'(3);
    localparam logic [height_b:0] c_min_h = (height_b+1)'(3);

    state_t                 r_state;
    state_t                 w_state_nxt;

    // Latched scan configuration and current (next-to-issue) window origin
    logic [width_b-1:0]     r_w;
    logic [height_b:0]      r_h;
    logic [1:0]             r_s;
    logic [width_b-1:0]     r_x;
    logic [height_b-1:0]    r_y;

    // Origin of the most recently issued window, re-timed onto out_x/out_y
    logic [width_b-1:0]     r_iss_x;
    logic [height_b-1:0]    r_iss_y;

    logic                   w_cfg_ok;
    logic                   w_accept;
    logic                   w_reject;
    logic                   w_issue;
    logic                   w_idle;
    logic [width_b-1:0]     w_cur_x;
    logic [height_b-1:0]    w_cur_y;
    logic [1:0]             w_cur_s;
    logic [width_b-1:0]     w_cur_w;
    logic [height_b:0]      w_cur_h;
    logic [width_b:0]       w_x_step;
    logic [width_b:0]       w_x_lim;
    logic [height_b:0]      w_y_step;
    logic [height_b:0]      w_y_lim;
    logic                   w_x_wrap;
    logic                   w_y_end;
    logic                   w_last;
    logic [width_b-1:0]     w_nxt_x;
    logic [height_b-1:0]    w_nxt_y;
    logic [width_b*9-1:0]   w_tap_w;
    logic [height_b*9-1:0]  w_tap_h;

    // Config acceptance and issue decision; the accepting start also issues
    // the (0,0) window so the first addresses appear the cycle after start.
    always_comb begin
        w_idle   = (r_state == S_IDLE);
        w_cfg_ok = ({1'b0, fmap_w} >= c_min_w) && ({1'b0, fmap_w} <= c_max_w) &&
                   (fmap_h >= c_min_h) && (fmap_h <= c_max_h);
        w_accept = w_idle && start && w_cfg_ok;
        w_reject = w_idle && start && !w_cfg_ok;
        w_issue  = w_accept || ((r_state == S_RUN) && !hold);
    end

    // Window being issued this cycle and the position that follows it
    always_comb begin
        w_cur_x  = w_idle ? '0 : r_x;
        w_cur_y  = w_idle ? '0 : r_y;
        w_cur_s  = w_idle ? (stride ? 2'd2 : 2'd1) : r_s;
        w_cur_w  = w_idle ? fmap_w : r_w;
        w_cur_h  = w_idle ? fmap_h : r_h;
        w_x_step = {1'b0, w_cur_x} + (width_b+1)'(w_cur_s);
        w_x_lim  = {1'b0, w_cur_w} - (width_b+1)'(3);
        w_y_step = {1'b0, w_cur_y} + (height_b+1)'(w_cur_s);
        w_y_lim  = w_cur_h - (height_b+1)'(3);
        w_x_wrap = (w_x_step > w_x_lim);
        w_y_end  = (w_y_step > w_y_lim);
        w_last   = w_x_wrap && w_y_end;
        w_nxt_x  = w_x_wrap ? '0 : w_x_step[width_b-1:0];
        w_nxt_y  = w_x_wrap ? w_y_step[height_b-1:0] : w_cur_y;
    end

    // Tap k sits at (x + k mod 3, y + k div 3); tap0 occupies the MSBs
    for (genvar k = 0; k < 9; k++) begin : g_tap
        localparam int c_dx = k % 3;
        localparam int c_dy = k / 3;
        assign w_tap_w[(8-k)*width_b +: width_b]   = w_cur_x + width_b'(c_dx);
        assign w_tap_h[(8-k)*height_b +: height_b] = w_cur_y + height_b'(c_dy);
    end

    // Next-state logic: the final issue moves to DRAIN for the last read beat
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_nxt = w_last ? S_DRAIN : S_RUN;
            S_RUN:   if (w_issue && w_last) w_state_nxt = S_DRAIN;
            S_DRAIN: w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Configuration latch, scan counters, registered addresses and status
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_w        <= '0;
            r_h        <= '0;
            r_s        <= '0;
            r_x        <= '0;
            r_y        <= '0;
            r_iss_x    <= '0;
            r_iss_y    <= '0;
            readi_w    <= '0;
            readi_h    <= '0;
            addr_valid <= 1'b0;
            fmap_valid <= 1'b0;
            out_x      <= '0;
            out_y      <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            cfg_err    <= 1'b0;
        end else begin
            if (w_accept) begin
                r_w <= fmap_w;
                r_h <= fmap_h;
                r_s <= w_cur_s;
            end
            if (w_issue) begin
                r_x     <= w_nxt_x;
                r_y     <= w_nxt_y;
                r_iss_x <= w_cur_x;
                r_iss_y <= w_cur_y;
                readi_w <= w_tap_w;
                readi_h <= w_tap_h;
            end
            addr_valid <= w_issue;
            fmap_valid <= addr_valid;
            out_x      <= r_iss_x;
            out_y      <= r_iss_y;
            done       <= (r_state == S_DRAIN);
            busy       <= w_accept || (r_state == S_RUN) || (r_state == S_DRAIN);
            cfg_err    <= w_reject;
        end
    end

endmodule
`default_nettype wire
